// File: rtl/conv_encoder_stream_pkg.sv
// -----------------------------------------------------------------------------
// conv_encoder_stream_pkg
// Shared definitions for the convolutional encoder and its matching Viterbi
// decoder. The decoder imports this same package, so both sides always agree
// on the generator polynomials and the symbol layout.
//
// Contents:
//   SYM_W        - bits per coded symbol ({g0, g1})
//   DEF_K        - default constraint length
//   DEF_G0/G1    - default generator polynomials (K bits, MSB = oldest bit)
//   enc_state_t  - encoder frame FSM encoding
// -----------------------------------------------------------------------------
package conv_encoder_stream_pkg;

  localparam int SYM_W = 2;

  localparam int         DEF_K  = 3;
  localparam logic [2:0] DEF_G0 = 3'b111;
  localparam logic [2:0] DEF_G1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    FIN  = 2'd3
  } enc_state_t;

endpackage

// File: rtl/conv_encoder_stream_sym_gen.sv
// -----------------------------------------------------------------------------
// conv_sym_gen
// Purely combinational rate-1/2 symbol generator. Given the K-bit register
// window r = {shift register, newest bit}, produces {parity(r&G0),
// parity(r&G1)}. Kept separate so the decoder's branch-metric logic can build
// its expected symbols from the very same function.
//
// Ports:
//   r    in  K      encoder window, r[0] is the newest bit
//   sym  out SYM_W  coded symbol {g0, g1}
// -----------------------------------------------------------------------------
module conv_sym_gen
  import conv_encoder_stream_pkg::*;
#(
  parameter int           K  = DEF_K,
  parameter logic [K-1:0] G0 = DEF_G0,
  parameter logic [K-1:0] G1 = DEF_G1
) (
  input  logic [K-1:0]     r,
  output logic [SYM_W-1:0] sym
);

  assign sym = {^(r & G0), ^(r & G1)};

endmodule

// File: rtl/conv_encoder_stream.sv
// -----------------------------------------------------------------------------
// conv_encoder_stream
// Streaming rate-1/2 convolutional encoder with zero-tail termination.
// A frame is opened by start in IDLE, carries frame_len data bits through a
// valid/ready input handshake, then M = K-1 zero bits are flushed through the
// same path so the decoder ends in state 0. Every input or tail bit produces
// one registered 2-bit symbol on a valid/ready output handshake.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   start      in   1      open a frame (only looked at in IDLE)
//   frame_len  in   8      number of data bits, latched when start is taken
//   in_valid   in   1      in_bit is valid
//   in_ready   out  1      encoder can take in_bit this cycle
//   in_bit     in   1      data bit
//   out_valid  out  1      out_sym is valid
//   out_ready  in   1      downstream accepts out_sym this cycle
//   out_sym    out  2      coded symbol {g0, g1}
//   busy       out  1      frame in progress (any state except IDLE)
//   done       out  1      single-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module conv_encoder_stream
  import conv_encoder_stream_pkg::*;
#(
  parameter int           K  = DEF_K,
  parameter logic [K-1:0] G0 = DEF_G0,
  parameter logic [K-1:0] G1 = DEF_G1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic             busy,
  output logic             done
);

  localparam int         M         = K - 1;
  localparam logic [2:0] TAIL_LAST = 3'(M);

  enc_state_t       state;
  enc_state_t       state_next;
  logic [M-1:0]     sr;
  logic [7:0]       len;
  logic [7:0]       cnt;
  logic [2:0]       tail_cnt;
  logic             out_slot;
  logic             bit_xfer;
  logic             tail_inject;
  logic             load;
  logic             load_bit;
  logic [K-1:0]     r;
  logic [SYM_W-1:0] sym;

  // The output register can take a new symbol if it is empty or being
  // drained this very cycle; this is what lets one symbol flow per cycle.
  assign out_slot    = !out_valid || out_ready;
  assign in_ready    = (state == DATA) && out_slot;
  assign bit_xfer    = in_valid && in_ready;
  assign tail_inject = (state == TAIL) && (tail_cnt != TAIL_LAST) && out_slot;
  assign load        = bit_xfer || tail_inject;

  // Tail bits are zeros pushed through the same window as data bits.
  assign load_bit = bit_xfer ? in_bit : 1'b0;
  assign r        = {sr, load_bit};
  assign busy     = (state != IDLE);

  conv_sym_gen #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_sym_gen (
    .r   (r),
    .sym (sym)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // TAIL leaves only once the last tail symbol is actually taken downstream,
  // so FIN (and the done pulse that follows it) never overtakes the data.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (frame_len == 8'd0) ? FIN : DATA;
        end
      end
      DATA: begin
        if (bit_xfer && (cnt == len - 8'd1)) begin
          state_next = TAIL;
        end
      end
      TAIL: begin
        if ((tail_cnt == TAIL_LAST) && out_slot) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: frame bookkeeping, shift register and the output symbol
  // register. A load takes priority over draining so that a transfer out and
  // a new bit in on the same edge both happen. done is registered from FIN,
  // so it appears the cycle after FIN while the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      len       <= '0;
      cnt       <= '0;
      tail_cnt  <= '0;
      out_valid <= 1'b0;
      out_sym   <= '0;
      done      <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        len      <= frame_len;
        cnt      <= '0;
        sr       <= '0;
        tail_cnt <= '0;
      end
      if (bit_xfer) begin
        cnt <= cnt + 8'd1;
      end
      if (tail_inject) begin
        tail_cnt <= tail_cnt + 3'd1;
      end
      if (load) begin
        out_sym   <= sym;
        out_valid <= 1'b1;
        sr        <= r[M-1:0];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      done <= (state == FIN);
    end
  end

endmodule
